// File: rtl/mb_io_timer.sv
// -----------------------------------------------------------------------------
// mb_io_timer
//
// Programmable down-counting timer on the MicroBlaze MCS IO bus. IO_Address
// selects one of eight word registers:
//   0 CTRL       bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, [8 +: PRESCALE_W] PRESCALE
//   1 LOAD       reload value
//   2 COUNT      live counter (a write loads it directly)
//   3 STATUS     bit0 EXPIRED, bit1 CAPTURED (sticky, write-1-to-clear)
//   4 CAPTURE    snapshot of COUNT taken on a rising edge of capture_in
//   5 EXPIRE_CNT number of expiries (any write clears it)
//   6,7          read as zero, writes ignored
//
// Every access completes one cycle after IO_Addr_Strobe with a single-cycle
// IO_Ready pulse. Read data is registered and is zero outside that pulse.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   IO_*             MCS IO bus slave interface
//   capture_in       capture event, already synchronous to clk
//   timer_irq        level interrupt = EXPIRED & IRQ_EN
//   timer_toggle     inverts on every expiry
// -----------------------------------------------------------------------------
module mb_io_timer #(
    parameter int COUNT_W    = 32,  // 8..32
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IO_Addr_Strobe,
    input  logic        IO_Read_Strobe,
    input  logic        IO_Write_Strobe,
    input  logic [2:0]  IO_Address,
    input  logic [3:0]  IO_Byte_Enable,
    input  logic [31:0] IO_Write_Data,
    output logic [31:0] IO_Read_Data,
    output logic        IO_Ready,
    input  logic        capture_in,
    output logic        timer_irq,
    output logic        timer_toggle
);

    typedef enum logic [2:0] {
        ADDR_CTRL       = 3'd0,
        ADDR_LOAD       = 3'd1,
        ADDR_COUNT      = 3'd2,
        ADDR_STATUS     = 3'd3,
        ADDR_CAPTURE    = 3'd4,
        ADDR_EXPIRE_CNT = 3'd5
    } reg_addr_e;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic                  ctrl_en;
    logic                  ctrl_auto;
    logic                  ctrl_irq_en;
    logic [PRESCALE_W-1:0] ctrl_prescale;
    logic [COUNT_W-1:0]    load_q;
    logic [COUNT_W-1:0]    count_q;
    logic [COUNT_W-1:0]    capture_q;
    logic                  expired;
    logic                  captured;
    logic [31:0]           expire_cnt;
    logic [PRESCALE_W-1:0] prescale_cnt;
    logic                  capture_prev;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_en, rd_en, any_be;
    logic wr_ctrl, wr_load, wr_count, wr_status, wr_expire_cnt;

    assign wr_en  = IO_Addr_Strobe && IO_Write_Strobe;
    assign rd_en  = IO_Addr_Strobe && IO_Read_Strobe;
    assign any_be = |IO_Byte_Enable;

    assign wr_ctrl       = wr_en && (IO_Address == ADDR_CTRL);
    assign wr_load       = wr_en && (IO_Address == ADDR_LOAD);
    assign wr_count      = wr_en && (IO_Address == ADDR_COUNT);
    // STATUS and EXPIRE_CNT do not merge bytes; any enabled lane triggers them.
    assign wr_status     = wr_en && (IO_Address == ADDR_STATUS) && any_be;
    assign wr_expire_cnt = wr_en && (IO_Address == ADDR_EXPIRE_CNT) && any_be;

    // ------------------------------------------------------------------
    // Byte-lane merge of write data into CTRL, LOAD and COUNT
    // ------------------------------------------------------------------
    logic                  ctrl_en_next;
    logic                  ctrl_auto_next;
    logic                  ctrl_irq_en_next;
    logic [PRESCALE_W-1:0] prescale_next;
    logic [COUNT_W-1:0]    load_next;
    logic [COUNT_W-1:0]    count_next;

    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        ctrl_en_next     = IO_Byte_Enable[0] ? IO_Write_Data[0] : ctrl_en;
        ctrl_auto_next   = IO_Byte_Enable[0] ? IO_Write_Data[1] : ctrl_auto;
        ctrl_irq_en_next = IO_Byte_Enable[0] ? IO_Write_Data[2] : ctrl_irq_en;
        prescale_next    = ctrl_prescale;
        load_next        = load_q;
        count_next       = count_q;
        for (int i = 0; i < PRESCALE_W; i++) begin
            if (IO_Byte_Enable[(8 + i) / 8]) begin
                prescale_next[i] = IO_Write_Data[8 + i];
            end
        end
        for (int i = 0; i < COUNT_W; i++) begin
            if (IO_Byte_Enable[i / 8]) begin
                load_next[i]  = IO_Write_Data[i];
                count_next[i] = IO_Write_Data[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (registered below)
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (IO_Address)
            ADDR_CTRL: begin
                rd_mux[0]                = ctrl_en;
                rd_mux[1]                = ctrl_auto;
                rd_mux[2]                = ctrl_irq_en;
                rd_mux[8 +: PRESCALE_W]  = ctrl_prescale;
            end
            ADDR_LOAD:       rd_mux = 32'(load_q);
            ADDR_COUNT:      rd_mux = 32'(count_q);
            ADDR_STATUS:     rd_mux = {30'd0, captured, expired};
            ADDR_CAPTURE:    rd_mux = 32'(capture_q);
            ADDR_EXPIRE_CNT: rd_mux = expire_cnt;
            default:         rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Timer events
    // ------------------------------------------------------------------
    logic tick, tick_eff, expire, cap_edge;

    assign tick     = ctrl_en && (prescale_cnt == ctrl_prescale);
    // A bus write to COUNT overrides the tick entirely, including any expiry.
    assign tick_eff = tick && !wr_count;
    assign expire   = tick_eff && (count_q == '0);
    assign cap_edge = capture_in && !capture_prev;

    assign timer_irq = expired && ctrl_irq_en;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value (e.g. the capture samples
    // COUNT before a same-cycle tick updates it).
    always_ff @(posedge clk) begin
        if (reset) begin
            IO_Ready      <= 1'b0;
            IO_Read_Data  <= '0;
            ctrl_en       <= 1'b0;
            ctrl_auto     <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            ctrl_prescale <= '0;
            load_q        <= '0;
            count_q       <= '0;
            capture_q     <= '0;
            expired       <= 1'b0;
            captured      <= 1'b0;
            expire_cnt    <= '0;
            prescale_cnt  <= '0;
            capture_prev  <= 1'b0;
            timer_toggle  <= 1'b0;
        end else begin
            // Bus handshake: every strobe, even with no direction, completes.
            IO_Ready     <= IO_Addr_Strobe;
            IO_Read_Data <= rd_en ? rd_mux : '0;

            capture_prev <= capture_in;

            // Prescaler restarts from zero when the timer is switched on,
            // otherwise it runs 0..PRESCALE while enabled and freezes when not.
            if (wr_ctrl && ctrl_en_next && !ctrl_en) begin
                prescale_cnt <= '0;
            end else if (ctrl_en) begin
                prescale_cnt <= tick ? '0 : prescale_cnt + PRESCALE_W'(1);
            end

            // Counter
            if (wr_count) begin
                count_q <= count_next;
            end else if (tick_eff) begin
                if (count_q != '0) begin
                    count_q <= count_q - COUNT_W'(1);
                end else if (ctrl_auto) begin
                    count_q <= load_q;
                end
            end

            // CTRL: a bus write takes priority over the one-shot auto-disable.
            if (wr_ctrl) begin
                ctrl_en       <= ctrl_en_next;
                ctrl_auto     <= ctrl_auto_next;
                ctrl_irq_en   <= ctrl_irq_en_next;
                ctrl_prescale <= prescale_next;
            end else if (expire && !ctrl_auto) begin
                ctrl_en <= 1'b0;
            end

            if (wr_load) begin
                load_q <= load_next;
            end

            // Sticky flags: a new event in the clearing cycle keeps the flag set.
            expired  <= (expired  && !(wr_status && IO_Write_Data[0])) || expire;
            captured <= (captured && !(wr_status && IO_Write_Data[1])) || cap_edge;

            if (cap_edge) begin
                capture_q <= count_q;
            end

            // Clear beats a same-cycle expiry; the counter wraps naturally.
            if (wr_expire_cnt) begin
                expire_cnt <= '0;
            end else if (expire) begin
                expire_cnt <= expire_cnt + 32'd1;
            end

            if (expire) begin
                timer_toggle <= !timer_toggle;
            end
        end
    end

endmodule

// File: tb/tb_mb_io_timer.sv
// -----------------------------------------------------------------------------
// tb_mb_io_timer
//
// Directed self-checking bench for mb_io_timer. Stimulus is applied one time
// unit after a rising edge and outputs are sampled at the same point, so the
// bench never races the DUT's clock edge. A free-running edge counter (cyc)
// lets cycle-exact scenarios be scheduled relative to the edge that enabled
// the timer.
// -----------------------------------------------------------------------------
module tb_mb_io_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        IO_Addr_Strobe;
    logic        IO_Read_Strobe;
    logic        IO_Write_Strobe;
    logic [2:0]  IO_Address;
    logic [3:0]  IO_Byte_Enable;
    logic [31:0] IO_Write_Data;
    logic [31:0] IO_Read_Data;
    logic        IO_Ready;
    logic        capture_in;
    logic        timer_irq;
    logic        timer_toggle;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mb_io_timer #(.COUNT_W(32), .PRESCALE_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .IO_Addr_Strobe  (IO_Addr_Strobe),
        .IO_Read_Strobe  (IO_Read_Strobe),
        .IO_Write_Strobe (IO_Write_Strobe),
        .IO_Address      (IO_Address),
        .IO_Byte_Enable  (IO_Byte_Enable),
        .IO_Write_Data   (IO_Write_Data),
        .IO_Read_Data    (IO_Read_Data),
        .IO_Ready        (IO_Ready),
        .capture_in      (capture_in),
        .timer_irq       (timer_irq),
        .timer_toggle    (timer_toggle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the edge numbered c.
    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk);
        #1;
        IO_Addr_Strobe  = 1'b1;
        IO_Write_Strobe = 1'b1;
        IO_Read_Strobe  = 1'b0;
        IO_Address      = a;
        IO_Write_Data   = d;
        IO_Byte_Enable  = be;
        @(posedge clk);
        #1;
        IO_Addr_Strobe  = 1'b0;
        IO_Write_Strobe = 1'b0;
        check("wr_ready", {31'd0, IO_Ready}, 32'd1);
    endtask

    task automatic bus_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(posedge clk);
        #1;
        IO_Addr_Strobe  = 1'b1;
        IO_Read_Strobe  = 1'b1;
        IO_Write_Strobe = 1'b0;
        IO_Address      = a;
        @(posedge clk);
        #1;
        IO_Addr_Strobe  = 1'b0;
        IO_Read_Strobe  = 1'b0;
        check({tag, "_ready"}, {31'd0, IO_Ready}, 32'd1);
        check(tag, IO_Read_Data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic exp_tog;

        reset           = 1'b1;
        IO_Addr_Strobe  = 1'b0;
        IO_Read_Strobe  = 1'b0;
        IO_Write_Strobe = 1'b0;
        IO_Address      = 3'd0;
        IO_Byte_Enable  = 4'h0;
        IO_Write_Data   = 32'd0;
        capture_in      = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  {31'd0, IO_Ready},     32'd0);
        check("rst_rdata",  IO_Read_Data,          32'd0);
        check("rst_irq",    {31'd0, timer_irq},    32'd0);
        check("rst_toggle", {31'd0, timer_toggle}, 32'd0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus_rd($sformatf("rst_word%0d", a), 3'(a), 32'd0);
            @(posedge clk);
            #1;
            check("rst_ready_1cyc", {31'd0, IO_Ready}, 32'd0);
        end

        // ---------------- one-shot ----------------
        bus_wr(3'd2, 32'd3, 4'hF);
        bus_wr(3'd0, 32'h0000_0005, 4'hF);
        base = cyc;                        // edge at which EN took effect
        goto_cyc(base + 3);
        check("os_irq_early",    {31'd0, timer_irq},    32'd0);
        check("os_toggle_early", {31'd0, timer_toggle}, 32'd0);
        goto_cyc(base + 4);
        check("os_irq",    {31'd0, timer_irq},    32'd1);
        check("os_toggle", {31'd0, timer_toggle}, 32'd1);
        bus_rd("os_ctrl",   3'd0, 32'h0000_0004);
        bus_rd("os_count",  3'd2, 32'd0);
        bus_rd("os_expcnt", 3'd5, 32'd1);
        bus_rd("os_status", 3'd3, 32'd1);
        bus_wr(3'd0, 32'd0, 4'hF);         // IRQ_EN off -> irq drops
        check("os_irq_en_off", {31'd0, timer_irq}, 32'd0);
        bus_rd("os_status_kept", 3'd3, 32'd1);
        bus_wr(3'd3, 32'd1, 4'h1);
        bus_rd("os_status_w1c", 3'd3, 32'd0);
        bus_wr(3'd5, 32'd0, 4'h1);
        bus_rd("expcnt_clear", 3'd5, 32'd0);

        // ---------------- auto-reload with prescaler ----------------
        bus_wr(3'd1, 32'd4, 4'hF);
        bus_wr(3'd2, 32'd4, 4'hF);
        bus_wr(3'd0, 32'h0000_0303, 4'hF);
        base    = cyc;
        exp_tog = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            goto_cyc(base + 20 * k - 1);
            check($sformatf("ar_tog_hold%0d", k), {31'd0, timer_toggle}, {31'd0, exp_tog});
            goto_cyc(base + 20 * k);
            exp_tog = ~exp_tog;
            check($sformatf("ar_tog_flip%0d", k), {31'd0, timer_toggle}, {31'd0, exp_tog});
        end
        bus_rd("ar_expcnt", 3'd5, 32'd5);  // sampled at base+102
        bus_wr(3'd3, 32'd1, 4'h1);         // clear EXPIRED at base+104

        // W1C landing on the expiry edge base+120: set wins
        goto_cyc(base + 118);
        bus_wr(3'd3, 32'd1, 4'h1);
        bus_rd("race_w1c_expired", 3'd3, 32'd1);   // sampled at base+122

        // COUNT write landing on tick edge base+124: write wins
        bus_wr(3'd2, 32'd9, 4'hF);
        bus_rd("race_count_wr", 3'd2, 32'd9);      // sampled at base+126
        bus_wr(3'd0, 32'd0, 4'hF);

        // ---------------- capture ----------------
        bus_wr(3'd1, 32'h100, 4'hF);
        bus_wr(3'd2, 32'h40, 4'hF);
        bus_wr(3'd3, 32'd3, 4'h1);
        bus_wr(3'd0, 32'h0000_0003, 4'hF);  // free-run, one decrement per cycle
        base = cyc;
        goto_cyc(base + 9);
        capture_in = 1'b1;                 // edge seen at base+10, COUNT=0x37
        goto_cyc(base + 10);
        capture_in = 1'b0;
        bus_rd("cap_value",  3'd4, 32'h37);
        bus_rd("cap_status", 3'd3, 32'h2);
        bus_wr(3'd3, 32'h2, 4'h1);
        bus_rd("cap_status_w1c", 3'd3, 32'd0);
        bus_wr(3'd0, 32'd0, 4'hF);

        // ---------------- byte enables ----------------
        bus_wr(3'd2, 32'h1234, 4'hF);
        bus_wr(3'd1, 32'd0, 4'hF);
        bus_wr(3'd1, 32'hAABB_CCDD, 4'b0101);
        bus_rd("be_load", 3'd1, 32'h00BB_00DD);
        bus_rd("load_no_count_effect", 3'd2, 32'h1234);
        bus_wr(3'd0, 32'hFFFF_FFFF, 4'b0010);
        bus_rd("be_ctrl", 3'd0, 32'h0000_FF00);
        bus_wr(3'd0, 32'd0, 4'hF);
        bus_wr(3'd6, 32'hFFFF_FFFF, 4'hF);
        bus_rd("word6", 3'd6, 32'd0);
        bus_rd("word7", 3'd7, 32'd0);

        // ---------------- back-to-back strobes ----------------
        @(posedge clk);
        #1;
        IO_Addr_Strobe = 1'b1;
        IO_Read_Strobe = 1'b1;
        IO_Address     = 3'd1;
        @(posedge clk);
        #1;
        check("b2b_ready0", {31'd0, IO_Ready}, 32'd1);
        check("b2b_data0",  IO_Read_Data, 32'h00BB_00DD);
        IO_Address = 3'd2;
        @(posedge clk);
        #1;
        check("b2b_ready1", {31'd0, IO_Ready}, 32'd1);
        check("b2b_data1",  IO_Read_Data, 32'h1234);
        IO_Addr_Strobe = 1'b0;
        IO_Read_Strobe = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_ready_end", {31'd0, IO_Ready}, 32'd0);

        // strobe with no direction still completes
        IO_Addr_Strobe = 1'b1;
        @(posedge clk);
        #1;
        IO_Addr_Strobe = 1'b0;
        check("nodir_ready", {31'd0, IO_Ready}, 32'd1);
        check("nodir_data",  IO_Read_Data, 32'd0);

        // ---------------- reset mid-access ----------------
        check("pre_rst_toggle", {31'd0, timer_toggle}, 32'd1);
        @(posedge clk);
        #1;
        IO_Addr_Strobe = 1'b1;
        IO_Read_Strobe = 1'b1;
        IO_Address     = 3'd1;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        IO_Addr_Strobe = 1'b0;
        IO_Read_Strobe = 1'b0;
        reset          = 1'b0;
        check("midrst_ready",  {31'd0, IO_Ready},     32'd0);
        check("midrst_data",   IO_Read_Data,          32'd0);
        check("midrst_toggle", {31'd0, timer_toggle}, 32'd0);
        bus_rd("midrst_load",  3'd1, 32'd0);
        bus_rd("midrst_count", 3'd2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mb_io_timer.md
# mb_io_timer

Programmable down-counting timer peripheral on the MicroBlaze MCS IO bus. It sits directly downstream of the MCS IO bus and is instantiated beside the register-test IO slave. It decodes `IO_Address[4:2]` into eight word registers. It provides a prescaled 32-bit down-counter with one-shot and auto-reload modes, a sticky expiry flag with a level interrupt, an expiry counter, and an edge-triggered capture register.

## Interface
Parameters:
- `COUNT_W`, default 32. Counter/LOAD/CAPTURE width, legal range 8..32. Reads zero-extend to 32 bits.
- `PRESCALE_W`, default 8. Width of the CTRL prescale field.

Ports:
- `clk` input 1: system clock (`clk_user` at top level).
- `reset` input 1: synchronous, active-high reset. Single clock domain.
- `IO_Addr_Strobe` input 1: one-cycle pulse marking a bus access.
- `IO_Read_Strobe` input 1: read access, qualified by `IO_Addr_Strobe`.
- `IO_Write_Strobe` input 1: write access, qualified by `IO_Addr_Strobe`.
- `IO_Address` input 3: word index, driven from `IO_Address[4:2]`.
- `IO_Byte_Enable` input 4: per-byte write enables; bit n enables byte n.
- `IO_Write_Data` input 32: write data.
- `IO_Read_Data` output 32: read data; valid only while `IO_Ready` is high, 0 otherwise.
- `IO_Ready` output 1: one-cycle access-complete pulse.
- `capture_in` input 1: capture event, already synchronous to `clk`.
- `timer_irq` output 1: level interrupt, equal to `STATUS.EXPIRED & CTRL.IRQ_EN`.
- `timer_toggle` output 1: inverts on every expiry.

## Operation
Register map (word index):
- 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[8+PRESCALE_W-1:8] PRESCALE. Other bits read 0.
- 1 LOAD: reload value.
- 2 COUNT: read returns the live counter; a write loads the counter directly.
- 3 STATUS: bit0 EXPIRED (sticky, write-1-to-clear), bit1 CAPTURED (sticky, W1C).
- 4 CAPTURE: read-only snapshot of COUNT.
- 5 EXPIRE_CNT: 32-bit expiry count, wraps at 2^32-1 to 0. Any write clears it.
- 6, 7: read 0; writes ignored.

Bus rules:
- Writes honour `IO_Byte_Enable` byte-wise on CTRL, LOAD and COUNT.
- STATUS and EXPIRE_CNT act on any enabled byte.

Prescaler and tick:
- While EN=1, the prescale counter counts 0..PRESCALE and wraps.
- A tick occurs on the cycle the prescale counter equals PRESCALE. Ticks are therefore spaced every PRESCALE+1 cycles.
- When EN goes from 0 to 1, the prescale counter clears.

Counter behaviour on a tick:
- If COUNT ≠ 0: COUNT decrements by 1.
- If COUNT = 0: an expiry occurs. EXPIRED sets, EXPIRE_CNT increments and `timer_toggle` inverts.
  - AUTO_RELOAD=1: COUNT loads LOAD.
  - AUTO_RELOAD=0: COUNT holds 0 and EN clears.
- Auto-reload period is (LOAD+1)·(PRESCALE+1) cycles.
- EN=0 freezes COUNT and the prescaler.

Capture:
- A rising edge of `capture_in` (registered previous value versus current) copies COUNT into CAPTURE and sets CAPTURED.

Simultaneous events:
- A bus write to COUNT in the same cycle as a tick: the write wins and the tick is discarded.
- W1C of EXPIRED in the same cycle as a new expiry: set wins, EXPIRED stays 1.
- W1C of CAPTURED in the same cycle as a capture edge: set wins.
- A capture in the same cycle as a tick samples COUNT before the tick update.
- EXPIRE_CNT clear in the same cycle as an expiry: the result is 0.
- Write to LOAD only; COUNT is unaffected until the next reload.

## Timing
- Reset values: all registers 0, `IO_Ready`=0, `IO_Read_Data`=0, `timer_irq`=0, `timer_toggle`=0, capture edge register 0.
- Access handshake:
  - `IO_Addr_Strobe` at cycle T produces `IO_Ready`=1 at T+1 for exactly one cycle.
  - Read data is registered and presented at T+1.
  - Write side effects are visible from T+1.
- Back-to-back strobes at T and T+1 produce `IO_Ready` at T+1 and T+2.
- A strobe with neither read nor write asserted still returns `IO_Ready`.
- `timer_irq` asserts the cycle after the expiry tick. It deasserts the cycle after the W1C write or after IRQ_EN is cleared.
- Reset mid-access: no `IO_Ready` is issued for the aborted access, and all state returns to reset values.

## Test plan
- Reset: assert `reset` for 3 cycles, then read words 0–7. Expect every read = 0, each with `IO_Ready` exactly 1 cycle after the strobe.
- One-shot: write COUNT=3, then CTRL=0x0000_0005 (EN, IRQ_EN, PRESCALE=0). Expect `timer_irq` high 4 cycles after EN takes effect, CTRL.EN reads 0, EXPIRE_CNT=1, COUNT=0.
- Auto-reload with prescaler: write LOAD=4, COUNT=4, CTRL=0x0000_0303 (PRESCALE=3). Expect `timer_toggle` to invert every 20 cycles. After 100 cycles EXPIRE_CNT=5.
- Byte enables: write LOAD=0xAABBCCDD with BE=4'b0101 over LOAD=0. Expect LOAD reads 0x00BB00DD.
- Race cases:
  - W1C STATUS=1 on the expiry cycle: EXPIRED stays 1.
  - Write COUNT=9 on a tick cycle: COUNT reads 9.
- Capture: with a free-running count, pulse `capture_in` while COUNT=0x37. Expect CAPTURE=0x37 and STATUS=0x2. W1C of STATUS bit1 then clears it to 0.
